// File: rtl/s2p.sv
// Serial-to-parallel deserializer: N bits LSB first in over valid/ready, one registered word out.
// Optional even-parity frame check is enabled with `define S2P_PARITY_EN (frame = N data + 1 parity bit).
module s2p #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ser_data,
  input  logic         ser_valid,
  output logic         ser_ready,
  output logic [N-1:0] par_data,
  output logic         par_valid,
  input  logic         par_ready,
  output logic         par_err
);

`ifdef S2P_PARITY_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif
  localparam int CW = $clog2(NB + 1);
  // The last bit of a frame is never shifted in, so the shifter only needs NB-1 bits.
  localparam int SW = NB - 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  logic [CW-1:0] r_count;
  logic [SW-1:0] r_shift;
  logic [N-1:0]  r_par_data;
  logic          r_par_valid;

  logic          w_bit_acc;
  logic          w_last;
  logic [SW-1:0] w_shift_next;
  logic [N-1:0]  w_word;

  assign w_last    = (r_count == LAST);
  assign ser_ready = !(w_last && r_par_valid);
  assign w_bit_acc = ser_valid && ser_ready;

  generate
    if (SW == 1) begin : g_shift_one
      assign w_shift_next = ser_data;
    end else begin : g_shift_many
      assign w_shift_next = {ser_data, r_shift[SW-1:1]};
    end
  endgenerate

`ifdef S2P_PARITY_EN
  assign w_word = r_shift;
`else
  assign w_word = {ser_data, r_shift};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count     <= '0;
      r_shift     <= '0;
      r_par_data  <= '0;
      r_par_valid <= 1'b0;
    end else begin
      if (w_bit_acc && !w_last) begin
        r_shift <= w_shift_next;
        r_count <= r_count + CW'(1);
      end
      // A load and a pop cannot coincide: ser_ready holds off the last bit while full.
      if (w_bit_acc && w_last) begin
        r_count     <= '0;
        r_par_data  <= w_word;
        r_par_valid <= 1'b1;
      end else if (r_par_valid && par_ready) begin
        r_par_valid <= 1'b0;
      end
    end
  end

`ifdef S2P_PARITY_EN
  logic r_par_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_par_err <= 1'b0;
    end else if (w_bit_acc && w_last) begin
      r_par_err <= ^{r_shift, ser_data};
    end
  end

  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

  assign par_data  = r_par_data;
  assign par_valid = r_par_valid;

endmodule

// File: tb/tb_s2p.sv
// Scoreboard bench for s2p (N=8); parity cases run when S2P_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_s2p;
  localparam int N = 8;
`ifdef S2P_PARITY_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         ser_data = 1'b0;
  logic         ser_valid = 1'b0;
  logic         ser_ready;
  logic [N-1:0] par_data;
  logic         par_valid;
  logic         par_ready = 1'b0;
  logic         par_err;

  int           n_vec = 0;
  int           n_err = 0;
  logic [N:0]   sb_q[$];
  logic [N:0]   mon_exp;
  bit           rand_rdy = 1'b0;

  s2p #(.N(N)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ser_data  (ser_data),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .par_data  (par_data),
    .par_valid (par_valid),
    .par_ready (par_ready),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Consumer side: every accepted parallel word is compared with the oldest expected one.
  always @(negedge clk) begin
    if (rstn && par_valid === 1'b1 && par_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_nonempty_on_pop", sb_q.size(), 1);
      end else begin
        mon_exp = sb_q.pop_front();
        $display("pop data=%02h err=%b exp=%02h/%b", par_data, par_err, mon_exp[N-1:0], mon_exp[N]);
        check("word", {par_err, par_data}, mon_exp);
      end
    end
  end

  // Returns at posedge+1 of the cycle in which the bit was accepted.
  task automatic send_bit(input logic b, input int gap);
    int n;
    while (gap > 0 && $urandom_range(0, 99) < gap) begin
      ser_valid = 1'b0;
      if (rand_rdy) par_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    ser_valid = 1'b1;
    ser_data  = b;
    n = 0;
    @(negedge clk);
    while (!ser_ready && n < 100) begin
      @(posedge clk); #1;
      if (rand_rdy) par_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (!ser_ready) check("ser_ready_timeout", ser_ready, 1);
    @(posedge clk); #1;
    ser_valid = 1'b0;
  endtask

  task automatic send_word(input logic [N-1:0] data, input logic flip, input int gap);
`ifdef S2P_PARITY_EN
    sb_q.push_back({flip, data});
`else
    sb_q.push_back({1'b0, data});
    if (flip) $display("note: parity flip ignored without parity");
`endif
    for (int i = 0; i < N; i++) send_bit(data[i], gap);
`ifdef S2P_PARITY_EN
    send_bit(^data ^ flip, 0);
`endif
  endtask

  task automatic drain(input string tag);
    par_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check(tag, sb_q.size(), 0);
  endtask

  function automatic logic [NB-1:0] frame(input logic [N-1:0] d);
    logic [NB-1:0] f;
    f = '0;
    f[N-1:0] = d;
`ifdef S2P_PARITY_EN
    f[N] = ^d;
`endif
    return f;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] fr;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_par_valid", par_valid, 0);
    check("rst_par_data", par_data, 0);
    check("rst_par_err", par_err, 0);
    check("rst_ser_ready", ser_ready, 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    par_ready = 1'b1;
    @(posedge clk); #1;

    // First word, latency of one cycle after the last bit
    fr = frame(8'hA5);
    sb_q.push_back({1'b0, 8'hA5});
    for (int i = 0; i < NB - 1; i++) send_bit(fr[i], 0);
    check("pre_last_valid", par_valid, 0);
    send_bit(fr[NB-1], 0);
    check("lat_valid", par_valid, 1);
    check("lat_data", par_data, 8'hA5);
    check("lat_err", par_err, 0);
    @(posedge clk); #1;
    check("pop_clears_valid", par_valid, 0);

    // Backpressure: hold 3C, collect C3 up to its last bit
    par_ready = 1'b0;
    send_word(8'h3C, 1'b0, 0);
    fr = frame(8'hC3);
    sb_q.push_back({1'b0, 8'hC3});
    for (int i = 0; i < NB - 1; i++) send_bit(fr[i], 0);
    ser_valid = 1'b1;
    ser_data  = fr[NB-1];
    repeat (3) begin
      @(negedge clk);
      check("bp_ser_ready", ser_ready, 0);
      check("bp_data", par_data, 8'h3C);
      check("bp_valid", par_valid, 1);
    end
    @(posedge clk); #1;
    par_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_before_pop", ser_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_ready_after_pop", ser_ready, 1);
    check("bp_bubble_valid", par_valid, 0);
    @(posedge clk); #1;
    ser_valid = 1'b0;
    check("bp_new_valid", par_valid, 1);
    check("bp_new_data", par_data, 8'hC3);
    drain("bp_drain");

    // Random serial gaps and random consumer stalls
    rand_rdy = 1'b1;
    for (int w = 0; w < 100; w++) send_word(8'($urandom), 1'($urandom_range(0, 1)), 50);
    rand_rdy = 1'b0;
    drain("rand_drain");

    // Reset mid-word with a held output word
    par_ready = 1'b0;
    send_word(8'h11, 1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    rstn = 1'b0;
    sb_q.delete();
    #1;
    check("async_rst_valid", par_valid, 0);
    @(negedge clk);
    check("mid_rst_valid", par_valid, 0);
    check("mid_rst_data", par_data, 0);
    check("mid_rst_err", par_err, 0);
    check("mid_rst_ready", ser_ready, 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    par_ready = 1'b1;
    send_word(8'h5A, 1'b0, 0);
    check("post_rst_data", par_data, 8'h5A);
    check("post_rst_valid", par_valid, 1);
    drain("rst_drain");

`ifdef S2P_PARITY_EN
    // Parity: good and corrupted frames
    send_word(8'h07, 1'b0, 0);
    check("par_good_err", par_err, 0);
    send_word(8'h07, 1'b1, 0);
    check("par_bad_err", par_err, 1);
    check("par_bad_data", par_data, 8'h07);
    drain("par_drain");
`endif

    // Back-to-back stream of every byte value
    par_ready = 1'b1;
    for (int w = 0; w < 256; w++) send_word(8'(w), 1'b0, 0);
    drain("loop_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
